// File: rtl/dm_ctrl_pkg.sv
// Shared encodings, defaults and request payload for the data-memory port arbiter.
package dm_ctrl_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   localparam logic [31:0]  ADDR_LIMIT_DEF     = 32'h0000_4000;
   localparam int unsigned  CPU_STREAK_MAX_DEF = 4;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] addr;
      logic [31:0] wd;
   } dm_req_t;

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane logic for one granted access: error decode, store
// byte-enables/replicated data, and load lane extraction with extension.
module dm_lane_align
   import dm_ctrl_pkg::*;
#(
   parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEF
) (
   input  dm_req_t     i_req,
   input  logic [31:0] i_mem_rd,
   output logic [3:0]  o_be_c,
   output logic [31:0] o_wd_c,
   output logic [31:0] o_rdata_c,
   output logic        o_err_c
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      o_err_c = 1'b0;
      case (i_req.size)
         SZ_BYTE: o_err_c = 1'b0;
         SZ_HALF: o_err_c = i_req.addr[0];
         SZ_WORD: o_err_c = |i_req.addr[1:0];
         default: o_err_c = 1'b1;
      endcase
      if (i_req.addr >= ADDR_LIMIT) o_err_c = 1'b1;
   end

   // Enables stay 0 for loads and errored accesses so nothing is written.
   always_comb begin
      o_be_c = 4'b0000;
      o_wd_c = i_req.wd;
      if (i_req.we && !o_err_c) begin
         case (i_req.size)
            SZ_BYTE: begin
               o_be_c = 4'b0001 << i_req.addr[1:0];
               o_wd_c = {4{i_req.wd[7:0]}};
            end
            SZ_HALF: begin
               o_be_c = i_req.addr[1] ? 4'b1100 : 4'b0011;
               o_wd_c = {2{i_req.wd[15:0]}};
            end
            SZ_WORD: o_be_c = 4'b1111;
            default: o_be_c = 4'b0000;
         endcase
      end
   end

   always_comb begin
      w_byte = i_mem_rd[7:0];
      case (i_req.addr[1:0])
         2'd0:    w_byte = i_mem_rd[7:0];
         2'd1:    w_byte = i_mem_rd[15:8];
         2'd2:    w_byte = i_mem_rd[23:16];
         default: w_byte = i_mem_rd[31:24];
      endcase
      w_half = i_req.addr[1] ? i_mem_rd[31:16] : i_mem_rd[15:0];
   end

   always_comb begin
      o_rdata_c = 32'h0;
      if (!i_req.we && !o_err_c) begin
         case (i_req.size)
            SZ_BYTE: o_rdata_c = i_req.sext ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
            SZ_HALF: o_rdata_c = i_req.sext ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
            SZ_WORD: o_rdata_c = i_mem_rd;
            default: o_rdata_c = 32'h0;
         endcase
      end
   end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage (C) and a
// DMA/bridge master (D); responses are registered one cycle after grant.
module dm_port_arbiter
   import dm_ctrl_pkg::*;
#(
   parameter logic [31:0] ADDR_LIMIT     = ADDR_LIMIT_DEF,
   parameter int unsigned CPU_STREAK_MAX = CPU_STREAK_MAX_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        c_req,
   input  logic        c_we,
   input  logic [1:0]  c_size,
   input  logic        c_sext,
   input  logic [31:0] c_addr,
   input  logic [31:0] c_wd,
   output logic        c_gnt,
   output logic        c_rvalid,
   output logic [31:0] c_rdata,
   output logic        c_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [1:0]  d_size,
   input  logic        d_sext,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wd,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   localparam int unsigned STREAK_W = $clog2(CPU_STREAK_MAX + 1);
   localparam logic [STREAK_W-1:0] STREAK_SAT = STREAK_W'(CPU_STREAK_MAX);

   logic [STREAK_W-1:0] r_streak;
   logic                r_c_rvalid, r_c_err, r_d_rvalid, r_d_err;
   logic [31:0]         r_c_rdata, r_d_rdata;

   logic        w_c_gnt, w_d_gnt, w_any_gnt, w_d_forced;
   dm_req_t     w_sel;
   logic [3:0]  w_be;
   logic [31:0] w_wd, w_rdata;
   logic        w_err;

   // Grants are suppressed while reset is high so no access slips through.
   always_comb begin
      w_d_forced = (r_streak >= STREAK_SAT);
      w_c_gnt    = !reset && c_req && (!d_req || !w_d_forced);
      w_d_gnt    = !reset && d_req && (!c_req || w_d_forced);
      w_any_gnt  = w_c_gnt || w_d_gnt;
   end

   always_comb begin
      if (w_d_gnt) w_sel = '{we: d_we, size: d_size, sext: d_sext, addr: d_addr, wd: d_wd};
      else         w_sel = '{we: c_we, size: c_size, sext: c_sext, addr: c_addr, wd: c_wd};
   end

   dm_lane_align #(
      .ADDR_LIMIT (ADDR_LIMIT)
   ) u_lane_align (
      .i_req     (w_sel),
      .i_mem_rd  (mem_rd),
      .o_be_c    (w_be),
      .o_wd_c    (w_wd),
      .o_rdata_c (w_rdata),
      .o_err_c   (w_err)
   );

   always_comb begin
      c_gnt    = w_c_gnt;
      d_gnt    = w_d_gnt;
      mem_we   = w_any_gnt && w_sel.we && !w_err;
      mem_be   = w_any_gnt ? w_be : 4'b0000;
      mem_addr = {w_sel.addr[31:2], 2'b00};
      mem_wd   = w_wd;
   end

   // Counts C wins while D waits; any cycle without a D request resets it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_streak <= '0;
      end else if (!d_req || w_d_gnt) begin
         r_streak <= '0;
      end else if (w_c_gnt && (r_streak < STREAK_SAT)) begin
         r_streak <= r_streak + STREAK_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_c_rvalid <= 1'b0;
         r_c_err    <= 1'b0;
         r_c_rdata  <= 32'h0;
         r_d_rvalid <= 1'b0;
         r_d_err    <= 1'b0;
         r_d_rdata  <= 32'h0;
      end else begin
         r_c_rvalid <= w_c_gnt;
         r_c_err    <= w_c_gnt && w_err;
         r_c_rdata  <= w_c_gnt ? w_rdata : 32'h0;
         r_d_rvalid <= w_d_gnt;
         r_d_err    <= w_d_gnt && w_err;
         r_d_rdata  <= w_d_gnt ? w_rdata : 32'h0;
      end
   end

   always_comb begin
      c_rvalid = r_c_rvalid;
      c_err    = r_c_err;
      c_rdata  = r_c_rdata;
      d_rvalid = r_d_rvalid;
      d_err    = r_d_err;
      d_rdata  = r_d_rdata;
   end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a small behavioural data memory.
module tb_dm_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        c_req, c_we, c_sext, d_req, d_we, d_sext;
   logic [1:0]  c_size, d_size;
   logic [31:0] c_addr, c_wd, d_addr, d_wd;
   logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
   logic [31:0] c_rdata, d_rdata;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wd, mem_rd;

   logic [31:0] mem [0:15];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   dm_port_arbiter dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_sext(c_sext),
      .c_addr(c_addr), .c_wd(c_wd), .c_gnt(c_gnt), .c_rvalid(c_rvalid),
      .c_rdata(c_rdata), .c_err(c_err),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_sext(d_sext),
      .d_addr(d_addr), .d_wd(d_wd), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
      .d_rdata(d_rdata), .d_err(d_err),
      .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   assign mem_rd = mem[mem_addr[5:2]];

   always @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wd[8*b +: 8];
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One access on port C (port=0) or D (port=1), checked in the grant and response cycles.
   task automatic access(input string tag, input logic port, input logic we,
                         input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd,
                         input logic [31:0] exp_rdata, input logic exp_err);
      @(negedge clk);
      if (port) begin
         d_req = 1'b1; d_we = we; d_size = size; d_sext = sext; d_addr = addr; d_wd = wd;
      end else begin
         c_req = 1'b1; c_we = we; c_size = size; c_sext = sext; c_addr = addr; c_wd = wd;
      end
      #1;
      check({tag, ".gnt"},    32'(port ? d_gnt : c_gnt), 32'd1);
      check({tag, ".other"},  32'(port ? c_gnt : d_gnt), 32'd0);
      check({tag, ".mem_we"}, 32'(mem_we), 32'(we && !exp_err));
      check({tag, ".mem_be"}, 32'(mem_be), 32'(exp_be));
      if (we && !exp_err) check({tag, ".mem_wd"}, mem_wd, exp_wd);
      @(posedge clk);
      #1;
      c_req = 1'b0;
      d_req = 1'b0;
      check({tag, ".rvalid"}, 32'(port ? d_rvalid : c_rvalid), 32'd1);
      check({tag, ".err"},    32'(port ? d_err : c_err), 32'(exp_err));
      check({tag, ".rdata"},  port ? d_rdata : c_rdata, exp_rdata);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      reset = 1'b1;
      c_req = 1'b0; c_we = 1'b0; c_size = 2'b00; c_sext = 1'b0; c_addr = 32'h0; c_wd = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_sext = 1'b0; d_addr = 32'h0; d_wd = 32'h0;
      #1;
      check("rst.c_rvalid", 32'(c_rvalid), 32'd0);
      check("rst.d_rvalid", 32'(d_rvalid), 32'd0);
      check("rst.c_rdata",  c_rdata, 32'h0);
      check("rst.c_gnt",    32'(c_gnt), 32'd0);
      check("rst.mem_we",   32'(mem_we), 32'd0);
      check("rst.mem_be",   32'(mem_be), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Store paths and lane replication
      access("sb3",  1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0003, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 32'h0, 1'b0);
      access("lbu3", 1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0, 4'b0000, 32'h0, 32'h0000_00AB, 1'b0);
      access("lb3",  1'b0, 1'b0, 2'b00, 1'b1, 32'h0000_0003, 32'h0, 4'b0000, 32'h0, 32'hFFFF_FFAB, 1'b0);
      access("dsw",  1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h8000_80F0, 4'b1111, 32'h8000_80F0, 32'h0, 1'b0);
      access("lb0",  1'b0, 1'b0, 2'b00, 1'b1, 32'h0000_0010, 32'h0, 4'b0000, 32'h0, 32'hFFFF_FFF0, 1'b0);
      access("lbu0", 1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0, 4'b0000, 32'h0, 32'h0000_00F0, 1'b0);
      access("lh2",  1'b0, 1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0, 4'b0000, 32'h0, 32'hFFFF_8000, 1'b0);
      access("lhu2", 1'b0, 1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0, 4'b0000, 32'h0, 32'h0000_8000, 1'b0);
      access("dlw",  1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 4'b0000, 32'h0, 32'h8000_80F0, 1'b0);
      access("sh2",  1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_1234, 4'b1100, 32'h1234_1234, 32'h0, 1'b0);
      access("lw20", 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 4'b0000, 32'h0, 32'h1234_0000, 1'b0);

      // Error cases: misaligned, out of range, illegal size
      access("lw6",   1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
      access("sw4k",  1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_4000, 32'hFFFF_FFFF, 4'b0000, 32'h0, 32'h0, 1'b1);
      access("sh1",   1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0021, 32'h0000_5555, 4'b0000, 32'h0, 32'h0, 1'b1);
      access("szill", 1'b0, 1'b0, 2'b11, 1'b0, 32'h0000_0020, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b1);
      access("lw20b", 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 4'b0000, 32'h0, 32'h1234_0000, 1'b0);

      // Contention: C,C,C,C,D repeating with both requests held
      @(negedge clk);
      c_req = 1'b1; c_we = 1'b0; c_size = 2'b10; c_sext = 1'b0; c_addr = 32'h0000_0020;
      d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_sext = 1'b0; d_addr = 32'h0000_0010;
      for (int i = 0; i < 12; i++) begin
         automatic logic exp_c = ((i % 5) != 4);
         #1;
         check($sformatf("arb%0d.c_gnt", i), 32'(c_gnt), 32'(exp_c));
         check($sformatf("arb%0d.d_gnt", i), 32'(d_gnt), 32'(!exp_c));
         @(posedge clk);
         #1;
         check($sformatf("arb%0d.c_rvalid", i), 32'(c_rvalid), 32'(exp_c));
         check($sformatf("arb%0d.d_rvalid", i), 32'(d_rvalid), 32'(!exp_c));
         if (exp_c) check($sformatf("arb%0d.c_rdata", i), c_rdata, 32'h1234_0000);
         else       check($sformatf("arb%0d.d_rdata", i), d_rdata, 32'h8000_80F0);
         @(negedge clk);
      end
      c_req = 1'b0;
      d_req = 1'b0;

      // Asynchronous reset while a response is showing and a store is pending
      @(negedge clk);
      c_req = 1'b1; c_we = 1'b0; c_size = 2'b10; c_addr = 32'h0000_0020;
      @(posedge clk);
      #1;
      check("rstmid.pre_rvalid", 32'(c_rvalid), 32'd1);
      c_we = 1'b1; c_addr = 32'h0000_0030; c_wd = 32'hDEAD_BEEF;
      #1;
      check("rstmid.pre_we", 32'(mem_we), 32'd1);
      #1;
      reset = 1'b1;
      #1;
      check("rstmid.c_rvalid", 32'(c_rvalid), 32'd0);
      check("rstmid.c_rdata",  c_rdata, 32'h0);
      check("rstmid.c_gnt",    32'(c_gnt), 32'd0);
      check("rstmid.mem_we",   32'(mem_we), 32'd0);
      check("rstmid.mem_be",   32'(mem_be), 32'd0);
      @(posedge clk);
      @(negedge clk);
      c_req = 1'b0;
      reset = 1'b0;
      access("lw30", 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0, 4'b0000, 32'h0, 32'h0, 1'b0);

      @(negedge clk);
      c_req = 1'b1; c_we = 1'b0; c_size = 2'b10; c_addr = 32'h0000_0020;
      d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h0000_0010;
      #1;
      check("post.c_gnt", 32'(c_gnt), 32'd1);
      check("post.d_gnt", 32'(d_gnt), 32'd0);
      @(negedge clk);
      c_req = 1'b0;
      d_req = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
